// File: rtl/obi_wb_pkg.sv
// Shared types and default region tables for OBI-to-Wishbone bridges.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_wb_pkg;

  // Bus widths that the packed request/response structs are built on.
  // Bridges using these structs keep ADDR_W/DATA_W equal to these values.
  localparam int OBI_WB_AW = 32;
  localparam int OBI_WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  typedef struct packed {
    logic [OBI_WB_AW-1:0]   addr;
    logic [OBI_WB_DW-1:0]   wdata;
    logic                   we;
    logic [OBI_WB_DW/8-1:0] sel;
  } wb_req_t;

  typedef struct packed {
    logic [OBI_WB_DW-1:0] rdata;
    logic                 err;
  } obi_rsp_t;

  // Default peripheral map: region 0 = 0xE0xx_xxxx, region 1 = 0xF0xx_xxxx,
  // both remapped to a zero-based 16 MB window. Index 0 sits in the LSBs.
  localparam int DEF_NUM_REGIONS = 2;
  localparam logic [DEF_NUM_REGIONS*OBI_WB_AW-1:0] DEF_REGION_BASE  = {32'hF000_0000, 32'hE000_0000};
  localparam logic [DEF_NUM_REGIONS*OBI_WB_AW-1:0] DEF_REGION_MASK  = {32'hFF00_0000, 32'hFF00_0000};
  localparam logic [DEF_NUM_REGIONS*OBI_WB_AW-1:0] DEF_REGION_REMAP = {32'h0000_0000, 32'h0000_0000};

endpackage

// File: rtl/obi_wb_addr_decode.sv
// Multi-region address decoder with per-region remap; lowest index wins on overlap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows i_addr.
// Ports: i_addr (incoming address), o_hit (some region matched),
//        o_region (winning region index), o_addr (remapped address, 0 on miss).
module obi_wb_addr_decode
  import obi_wb_pkg::*;
#(
  parameter int ADDR_W      = OBI_WB_AW,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK  = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_REMAP = DEF_REGION_REMAP
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [REG_W-1:0]  o_region,
  output logic [ADDR_W-1:0] o_addr
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    o_hit    = 1'b0;
    o_region = '0;
    o_addr   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((i_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        o_hit    = 1'b1;
        o_region = REG_W'(i);
        o_addr   = REGION_REMAP[i*ADDR_W +: ADDR_W] | (i_addr & ~REGION_MASK[i*ADDR_W +: ADDR_W]);
      end
    end
  end

endmodule

// File: rtl/obi_wb_bridge_mr.sv
// OBI slave to Wishbone-classic master bridge with region decode, remap, bus errors and timeout.
// Latency: grant in cycle 0, cyc in cycle 1, rvalid one cycle after ack/err (unmapped: rvalid in cycle 1).
// Backpressure: one transaction outstanding; obi_gnt_o only in IDLE, so new requests wait until the response is done.
// Ports: clk_i/rst_i (sync active-high reset); obi_* OBI slave side (req/gnt, addr, we, be,
//        wdata, rvalid/rdata/err); wb_* Wishbone master side (addr, wdata, rdata, we, sel,
//        stb, cyc, ack, err); region_o index of the region being accessed while cyc is high.
module obi_wb_bridge_mr
  import obi_wb_pkg::*;
#(
  parameter int ADDR_W      = OBI_WB_AW,
  parameter int DATA_W      = OBI_WB_DW,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK  = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_REMAP = DEF_REGION_REMAP,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int REG_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic                obi_we_i,
  input  logic [DATA_W/8-1:0] obi_be_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic                obi_err_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_wdata_o,
  input  logic [DATA_W-1:0]   wb_rdata_i,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic [REG_W-1:0]    region_o
);

  bridge_state_e     r_state, w_state_nxt;
  wb_req_t           r_req, w_req_nxt;
  obi_rsp_t          r_rsp, w_rsp_nxt;
  logic [REG_W-1:0]  r_region, w_region_nxt;

  logic              w_hit;
  logic [REG_W-1:0]  w_region;
  logic [ADDR_W-1:0] w_remap;
  logic              w_timeout;
  logic              w_in_bus;

  obi_wb_addr_decode #(
    .ADDR_W       (ADDR_W),
    .NUM_REGIONS  (NUM_REGIONS),
    .REG_W        (REG_W),
    .REGION_BASE  (REGION_BASE),
    .REGION_MASK  (REGION_MASK),
    .REGION_REMAP (REGION_REMAP)
  ) u_decode (
    .i_addr   (obi_addr_i),
    .o_hit    (w_hit),
    .o_region (w_region),
    .o_addr   (w_remap)
  );

  assign w_in_bus = (r_state == BUS);

  // Timeout counter: holds the number of BUS cycles already completed, so the
  // comparison against TIMEOUT_CYCLES-1 fires on the last allowed BUS cycle.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i || !w_in_bus || (w_state_nxt != BUS)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_rsp_nxt    = r_rsp;
    w_region_nxt = r_region;
    obi_gnt_o    = 1'b0;
    case (r_state)
      IDLE: begin
        // A request seen during reset would be dropped, so it is not granted.
        obi_gnt_o = obi_req_i & ~rst_i;
        if (obi_req_i) begin
          if (w_hit) begin
            w_req_nxt.addr  = w_remap;
            w_req_nxt.wdata = obi_wdata_i;
            w_req_nxt.we    = obi_we_i;
            w_req_nxt.sel   = obi_be_i;
            w_region_nxt    = w_region;
            w_state_nxt     = BUS;
          end else begin
            w_rsp_nxt.rdata = '0;
            w_rsp_nxt.err   = 1'b1;
            w_state_nxt     = RESP;
          end
        end
      end
      BUS: begin
        // Priority: slave error, then ack, then timeout.
        if (wb_err_i) begin
          w_rsp_nxt.rdata = '0;
          w_rsp_nxt.err   = 1'b1;
          w_state_nxt     = RESP;
        end else if (wb_ack_i) begin
          w_rsp_nxt.rdata = r_req.we ? '0 : wb_rdata_i;
          w_rsp_nxt.err   = 1'b0;
          w_state_nxt     = RESP;
        end else if (w_timeout) begin
          w_rsp_nxt.rdata = '0;
          w_rsp_nxt.err   = 1'b1;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_rsp    <= '0;
      r_region <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_rsp    <= w_rsp_nxt;
      r_region <= w_region_nxt;
    end
  end

  // we/sel are qualified by cyc so they drop on the same edge that ends the cycle.
  assign wb_cyc_o     = w_in_bus;
  assign wb_stb_o     = w_in_bus;
  assign wb_addr_o    = r_req.addr;
  assign wb_wdata_o   = r_req.wdata;
  assign wb_we_o      = r_req.we & w_in_bus;
  assign wb_sel_o     = r_req.sel & {(DATA_W/8){w_in_bus}};
  assign region_o     = r_region;
  assign obi_rvalid_o = (r_state == RESP);
  assign obi_rdata_o  = r_rsp.rdata;
  assign obi_err_o    = r_rsp.err;

endmodule

// File: tb/tb_obi_wb_bridge_mr.sv
module tb_obi_wb_bridge_mr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_rdata_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [0:0]  region_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  obi_wb_bridge_mr #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .wb_addr_o    (wb_addr_o),
    .wb_wdata_o   (wb_wdata_o),
    .wb_rdata_i   (wb_rdata_i),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_stb_o     (wb_stb_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .region_o     (region_o)
  );

  // One transaction: request, slave behaviour and the expected result.
  // ack_at is the BUS cycle (1-based) in which the slave responds; 0 = silent.
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_at;
    logic        rsp_ack;
    logic        rsp_err;
    logic [31:0] slv_rdata;
    logic        hit;
    logic [31:0] exp_addr;
    logic        exp_region;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_bus;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns at the falling edge of the last cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          nrv;
    int          nbus;
    logic        g;
    logic        c0;
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        reg_idx;
    string       tag;
    lat = -1; nrv = 0; nbus = 0;
    rd = '0; er = 1'b0; a = '0; wd = '0; we = 1'b0; sel = '0; stb = 1'b0; reg_idx = 1'b0;
    tag = $sformatf("v%0d", idx);
    obi_req_i   = 1'b1;
    obi_addr_i  = v.addr;
    obi_we_i    = v.we;
    obi_be_i    = v.be;
    obi_wdata_i = v.wdata;
    @(negedge clk_i);
    g  = obi_gnt_o;
    c0 = wb_cyc_o;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk_i); #1;
      obi_req_i  = 1'b0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_rdata_i = 32'hBAD0_0000;
      if (wb_cyc_o) begin
        nbus++;
        if (nbus == 1) begin
          a = wb_addr_o; wd = wb_wdata_o; we = wb_we_o; sel = wb_sel_o;
          stb = wb_stb_o; reg_idx = region_o[0];
        end
        if (nbus == v.ack_at) begin
          wb_ack_i   = v.rsp_ack;
          wb_err_i   = v.rsp_err;
          wb_rdata_i = v.slv_rdata;
        end
      end
      @(negedge clk_i);
      if (obi_rvalid_o) begin
        nrv++;
        if (lat < 0) begin
          lat = c; rd = obi_rdata_o; er = obi_err_o;
        end
      end
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk({tag, " gnt"},        {31'd0, g},  32'd1);
    chk({tag, " cyc_c0"},     {31'd0, c0}, 32'd0);
    chk({tag, " latency"},    lat,         v.exp_lat);
    chk({tag, " rvalid_cnt"}, nrv,         32'd1);
    chk({tag, " rdata"},      rd,          v.exp_rdata);
    chk({tag, " err"},        {31'd0, er}, {31'd0, v.exp_err});
    chk({tag, " bus_cycles"}, nbus,        v.exp_bus);
    chk({tag, " cyc_after"},  {31'd0, wb_cyc_o}, 32'd0);
    if (v.hit) begin
      chk({tag, " wb_addr"}, a,                {31'd0, 1'b0} | v.exp_addr);
      chk({tag, " wb_we"},   {31'd0, we},      {31'd0, v.we});
      chk({tag, " wb_sel"},  {28'd0, sel},     {28'd0, v.be});
      chk({tag, " wb_stb"},  {31'd0, stb},     32'd1);
      chk({tag, " region"},  {31'd0, reg_idx}, {31'd0, v.exp_region});
      if (v.we) chk({tag, " wb_wdata"}, wd, v.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrv;
    //          addr          we  be    wdata         at ack err slv_rdata     hit exp_addr     rg exp_rdata     err lat bus
    vecs[0] = '{32'hE000_0010, 0, 4'hF, 32'h0,         3, 1, 0, 32'hCAFE_F00D, 1, 32'h0000_0010, 0, 32'hCAFE_F00D, 0, 4, 3};
    vecs[1] = '{32'hF000_0004, 1, 4'h3, 32'h1234_5678, 1, 1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0004, 1, 32'h0,         0, 2, 1};
    vecs[2] = '{32'h1000_0000, 0, 4'hF, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 0};
    vecs[3] = '{32'hE000_0020, 0, 4'hF, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_0020, 0, 32'h0,         1, 5, 4};
    vecs[4] = '{32'hF000_0100, 0, 4'hF, 32'h0,         2, 1, 1, 32'h1111_2222, 1, 32'h0000_0100, 1, 32'h0,         1, 3, 2};
    vecs[5] = '{32'hE012_3458, 1, 4'hC, 32'hA5A5_0F0F, 1, 0, 1, 32'h0,         1, 32'h0012_3458, 0, 32'h0,         1, 2, 1};
    vecs[6] = '{32'hF0FF_FFFC, 0, 4'hF, 32'h0,         4, 1, 0, 32'h5A5A_A5A5, 1, 32'h00FF_FFFC, 1, 32'h5A5A_A5A5, 0, 5, 4};
    vecs[7] = '{32'hDFFF_FFFC, 0, 4'hF, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 1, 0};
    vecs[8] = '{32'hE0FF_FFF0, 0, 4'h1, 32'h0,         1, 1, 0, 32'h0BAD_F00D, 1, 32'h00FF_FFF0, 0, 32'h0BAD_F00D, 0, 2, 1};

    // Reset state, with request and slave inputs deliberately active.
    rst_i = 1'b1; obi_req_i = 1'b1; obi_addr_i = 32'hE000_0000; obi_we_i = 1'b1;
    obi_be_i = 4'hF; obi_wdata_i = 32'hFFFF_FFFF; wb_rdata_i = 32'hFFFF_FFFF;
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst gnt",    {31'd0, obi_gnt_o},    32'd0);
    chk("rst rvalid", {31'd0, obi_rvalid_o}, 32'd0);
    chk("rst err",    {31'd0, obi_err_o},    32'd0);
    chk("rst rdata",  obi_rdata_o,           32'd0);
    chk("rst cyc",    {31'd0, wb_cyc_o},     32'd0);
    chk("rst stb",    {31'd0, wb_stb_o},     32'd0);
    chk("rst we",     {31'd0, wb_we_o},      32'd0);
    chk("rst sel",    {28'd0, wb_sel_o},     32'd0);
    chk("rst addr",   wb_addr_o,             32'd0);
    chk("rst region", {31'd0, region_o[0]},  32'd0);
    @(posedge clk_i); #1;
    obi_req_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk_i); #1;
      run_vec(vecs[i], i);
    end

    // Timeout again, then stray ack/err in IDLE must be ignored and the
    // previous response must hold.
    @(posedge clk_i); #1;
    run_vec(vecs[3], 3);
    nrv = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      wb_ack_i = 1'b1; wb_err_i = (c == 1); wb_rdata_i = 32'h7777_7777;
      @(negedge clk_i);
      if (obi_rvalid_o || wb_cyc_o) nrv++;
    end
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge clk_i);
    chk("stray no_activity", nrv, 32'd0);
    chk("stray err_hold",    {31'd0, obi_err_o}, 32'd1);
    chk("stray rdata_hold",  obi_rdata_o, 32'd0);

    // Reset while in BUS: cycle dropped, no response, next access is clean.
    @(posedge clk_i); #1;
    obi_req_i = 1'b1; obi_addr_i = 32'hE000_0040; obi_we_i = 1'b0; obi_be_i = 4'hF;
    @(posedge clk_i); #1;
    obi_req_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("midrst cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("midrst stb", {31'd0, wb_stb_o}, 32'd0);
    nrv = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (obi_rvalid_o || wb_cyc_o) nrv++;
    end
    chk("midrst no_rvalid", nrv, 32'd0);
    @(posedge clk_i); #1;
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
